// File: rtl/pc_gen.sv
// Program-counter generator with prioritised redirects and a circular return-address stack.
// Misaligned redirect targets are forced onto the alignment grid and flagged for one cycle.
`timescale 1ns/1ps
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 'h0000_3000,
    parameter int               RAS_DEPTH = 4,
    parameter int               ALIGN     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             jalr,
    input  logic             ret,
    input  logic             call,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full
);
    localparam int               PTR_W    = $clog2(RAS_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << ALIGN) - WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [PTR_W-1:0] top_q, top_d, topAfterPop;
    logic [CNT_W-1:0] cnt_q, cnt_d, cntAfterPop;
    logic [WIDTH-1:0] rasMem [RAS_DEPTH];
    logic [WIDTH-1:0] rawTarget;
    logic             redirect;
    logic             popEn;

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + WIDTH'(4);
    assign misalign  = misalign_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_MAX);

    // A ret pops whenever the stack has an entry, even if jalr/br_taken wins the target,
    // so the stack stays in step with the return instructions actually executed.
    always_comb begin
        rawTarget = pc_plus4;
        redirect  = 1'b0;
        popEn     = ret && !ras_empty;
        if (jalr) begin
            rawTarget = (base + imm) & ~WIDTH'(1);
            redirect  = 1'b1;
        end else if (br_taken) begin
            rawTarget = pc_q + imm;
            redirect  = 1'b1;
        end else if (popEn) begin
            rawTarget = rasMem[top_q];
            redirect  = 1'b1;
        end
        pc_d       = rawTarget & ~LOW_MASK;
        misalign_d = redirect && ((rawTarget & LOW_MASK) != '0);

        // Pop happens before push; a push onto a full stack wraps onto the oldest slot.
        topAfterPop = popEn ? top_q - PTR_W'(1) : top_q;
        cntAfterPop = popEn ? cnt_q - CNT_W'(1) : cnt_q;
        top_d       = topAfterPop;
        cnt_d       = cntAfterPop;
        if (call) begin
            top_d = topAfterPop + PTR_W'(1);
            cnt_d = (cntAfterPop == CNT_MAX) ? CNT_MAX : cntAfterPop + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            top_q      <= '0;
            cnt_q      <= '0;
        end else if (!stall) begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            top_q      <= top_d;
            cnt_q      <= cnt_d;
        end
    end

    // Entry contents need no reset: they are unreachable while the count is zero.
    always_ff @(posedge clk) begin
        if (!rst && !stall && call) begin
            rasMem[top_d] <= pc_plus4;
        end
    end
endmodule
